// File: rtl/imem_boot_arbiter.sv
// Shares the single instruction-memory port between IF fetch and a word loader: boot load, drain, then run with bounded-starvation patch writes.
// Writes issue one cycle after accept; fetch is a zero-cycle combinational path through the memory.
module imem_boot_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        ld_done,
   output logic        cpu_run,
   input  logic        fetch_req,
   input  logic [31:0] fetch_pc,
   output logic [31:0] fetch_instr,
   output logic        fetch_valid,
   output logic        fetch_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [12:0] words_loaded,
   output logic        err_misaligned
);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_RUN   = 2'd3;

   localparam int          SC_W      = $clog2(STARVE_MAX + 1);
   localparam logic [31:0] LAST_WORD = (32'd1 << ADDR_W) - 32'd4;

   logic [1:0]      state;
   logic [31:0]     wr_addr;
   logic [31:0]     wr_data;
   logic            wr_pend;
   logic [SC_W-1:0] starve_cnt;

   logic accept;
   logic misaligned;
   logic out_of_range;
   logic starved;

   assign misaligned   = (ld_addr[1:0] != 2'b00);
   assign out_of_range = (ld_addr > LAST_WORD);
   assign starved      = (starve_cnt == SC_W'(STARVE_MAX));

   always_comb begin
      ld_ready = 1'b0;
      case (state)
         S_LOAD:  ld_ready = 1'b1;
         S_RUN:   ld_ready = (!fetch_req || starved) && !wr_pend;
         default: ld_ready = 1'b0;
      endcase
   end

   assign accept = ld_valid && ld_ready;

   assign mem_we    = wr_pend;
   assign mem_wdata = wr_data;
   assign mem_addr  = wr_pend ? wr_addr : fetch_pc;

   assign fetch_err   = fetch_req && (fetch_pc > LAST_WORD);
   assign fetch_valid = (state == S_RUN) && fetch_req && !wr_pend && !fetch_err;
   assign fetch_instr = fetch_valid ? mem_rdata : 32'd0;

   // ld_done is only honoured in LOAD; a word accepted alongside it still
   // drains during DRAIN, so the pipeline never sees a stale image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_INIT;
         cpu_run <= 1'b0;
      end else begin
         case (state)
            S_INIT:  state <= S_LOAD;
            S_LOAD:  if (ld_done) state <= S_DRAIN;
            S_DRAIN: begin
               state   <= S_RUN;
               cpu_run <= 1'b1;
            end
            default: state <= S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_pend        <= 1'b0;
         wr_addr        <= 32'd0;
         wr_data        <= 32'd0;
         err_misaligned <= 1'b0;
      end else begin
         wr_pend <= accept && !misaligned && !out_of_range;
         if (accept) begin
            wr_addr <= ld_addr;
            wr_data <= ld_data;
            if (misaligned) err_misaligned <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words_loaded <= 13'd0;
      end else if (wr_pend && (words_loaded != 13'h1FFF)) begin
         words_loaded <= words_loaded + 13'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state != S_RUN || accept || !ld_valid) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a big-endian byte memory model on the memory port.
module tb_imem_boot_arbiter;

   logic        clk;
   logic        rst;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        ld_done;
   logic        cpu_run;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        fetch_valid;
   logic        fetch_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [12:0] words_loaded;
   logic        err_misaligned;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem [0:16383];
   logic [13:0] ra;

   imem_boot_arbiter #(.ADDR_W(14), .STARVE_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_done(ld_done), .cpu_run(cpu_run),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_valid(fetch_valid), .fetch_err(fetch_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .words_loaded(words_loaded), .err_misaligned(err_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ra        = mem_addr[13:0];
   assign mem_rdata = {mem[ra], mem[ra + 14'd1], mem[ra + 14'd2], mem[ra + 14'd3]};

   always @(posedge clk) begin
      if (mem_we) begin
         mem[ra]         <= mem_wdata[31:24];
         mem[ra + 14'd1] <= mem_wdata[23:16];
         mem[ra + 14'd2] <= mem_wdata[15:8];
         mem[ra + 14'd3] <= mem_wdata[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      rst = 1'b1; ld_valid = 1'b0; ld_addr = 32'd0; ld_data = 32'd0;
      ld_done = 1'b0; fetch_req = 1'b0; fetch_pc = 32'd0;
      tick(); tick();
      @(negedge clk);
      check("rst_cpu_run",  32'(cpu_run), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_mem_we",   32'(mem_we), 32'd0);
      check("rst_words",    32'(words_loaded), 32'd0);
      check("rst_err_mis",  32'(err_misaligned), 32'd0);
      check("rst_fvalid",   32'(fetch_valid), 32'd0);
      check("rst_finstr",   fetch_instr, 32'd0);

      // Release: INIT for one cycle, then LOAD
      tick(); rst = 1'b0;
      fetch_req = 1'b1; fetch_pc = 32'd100;
      @(negedge clk);
      check("init_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      ld_valid = 1'b1; ld_addr = 32'd100; ld_data = 32'h4808_0000;
      @(negedge clk);
      check("load_ld_ready", 32'(ld_ready), 32'd1);
      check("load_fvalid_a", 32'(fetch_valid), 32'd0);
      check("load_we_a",     32'(mem_we), 32'd0);
      tick();
      ld_addr = 32'd104; ld_data = 32'h4809_0004;
      @(negedge clk);
      check("wr1_we",       32'(mem_we), 32'd1);
      check("wr1_addr",     mem_addr, 32'd100);
      check("wr1_data",     mem_wdata, 32'h4808_0000);
      check("load_fvalid_b", 32'(fetch_valid), 32'd0);
      tick();
      ld_addr = 32'd102; ld_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("wr2_we",   32'(mem_we), 32'd1);
      check("wr2_addr", mem_addr, 32'd104);
      check("wr2_data", mem_wdata, 32'h4809_0004);
      check("mis_accept", 32'(ld_ready), 32'd1);
      tick();
      // word accepted in the same cycle as ld_done must still be written
      ld_addr = 32'd108; ld_data = 32'h1122_3344; ld_done = 1'b1;
      @(negedge clk);
      check("mis_no_we",  32'(mem_we), 32'd0);
      check("mis_flag",   32'(err_misaligned), 32'd1);
      check("words_2",    32'(words_loaded), 32'd2);
      check("done_ready", 32'(ld_ready), 32'd1);
      tick();
      ld_valid = 1'b0; ld_done = 1'b0; fetch_pc = 32'd104;
      @(negedge clk);
      check("drain_ready",  32'(ld_ready), 32'd0);
      check("drain_we",     32'(mem_we), 32'd1);
      check("drain_addr",   mem_addr, 32'd108);
      check("drain_run",    32'(cpu_run), 32'd0);
      check("drain_fvalid", 32'(fetch_valid), 32'd0);
      tick();
      @(negedge clk);
      check("run_cpu_run", 32'(cpu_run), 32'd1);
      check("words_3",     32'(words_loaded), 32'd3);
      check("mis_sticky",  32'(err_misaligned), 32'd1);
      check("f104_valid",  32'(fetch_valid), 32'd1);
      check("f104_instr",  fetch_instr, 32'h4809_0004);
      check("f104_addr",   mem_addr, 32'd104);
      fetch_pc = 32'd108; #1;
      check("f108_instr", fetch_instr, 32'h1122_3344);
      fetch_pc = 32'd100; #1;
      check("f100_instr", fetch_instr, 32'h4808_0000);
      fetch_pc = 32'd16381; #1;
      check("rng_err_hi",   32'(fetch_err), 32'd1);
      check("rng_valid_hi", 32'(fetch_valid), 32'd0);
      check("rng_instr_hi", fetch_instr, 32'd0);
      fetch_pc = 32'd16380; #1;
      check("rng_err_ok",   32'(fetch_err), 32'd0);
      check("rng_valid_ok", 32'(fetch_valid), 32'd1);
      fetch_req = 1'b0; #1;
      check("run_idle_ready", 32'(ld_ready), 32'd1);

      // Starvation: 8 refused cycles, then forced through
      tick();
      fetch_req = 1'b1; fetch_pc = 32'd104;
      ld_valid = 1'b1; ld_addr = 32'd296; ld_data = 32'h0C10_0008;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("starve_refuse_%0d", i), 32'(ld_ready), 32'd0);
         check($sformatf("starve_fvalid_%0d", i), 32'(fetch_valid), 32'd1);
         tick();
      end
      @(negedge clk);
      check("starve_ready", 32'(ld_ready), 32'd1);
      tick();
      ld_valid = 1'b0;
      @(negedge clk);
      check("forced_we",     32'(mem_we), 32'd1);
      check("forced_addr",   mem_addr, 32'd296);
      check("forced_fvalid", 32'(fetch_valid), 32'd0);
      tick();
      @(negedge clk);
      check("retry_fvalid", 32'(fetch_valid), 32'd1);
      check("retry_instr",  fetch_instr, 32'h4809_0004);
      check("words_4",      32'(words_loaded), 32'd4);
      fetch_pc = 32'd296; #1;
      check("f296_instr", fetch_instr, 32'h0C10_0008);

      // Reset mid-load
      tick(); rst = 1'b1; fetch_req = 1'b0;
      tick(); rst = 1'b0;
      tick();
      ld_valid = 1'b1; ld_addr = 32'd200; ld_data = 32'hCAFE_F00D;
      @(negedge clk);
      check("rl_ready", 32'(ld_ready), 32'd1);
      tick();
      ld_valid = 1'b0;
      @(negedge clk);
      check("rl_we_before", 32'(mem_we), 32'd1);
      rst = 1'b1; #1;
      check("rl_we_drop", 32'(mem_we), 32'd0);
      check("rl_words",   32'(words_loaded), 32'd0);
      check("rl_cpu_run", 32'(cpu_run), 32'd0);
      check("rl_mis",     32'(err_misaligned), 32'd0);
      tick(); rst = 1'b0;
      @(negedge clk);
      check("rl_init_ready", 32'(ld_ready), 32'd0);
      tick();
      @(negedge clk);
      check("rl_load_ready", 32'(ld_ready), 32'd1);
      check("rl_words_after", 32'(words_loaded), 32'd0);
      fetch_req = 1'b1; fetch_pc = 32'd200; #1;
      check("rl_fetch_blocked", 32'(fetch_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_arbiter.md
# imem_boot_arbiter

Owns the single port of the byte-addressed, big-endian instruction memory and shares it between the processor fetch stage and a word-wide program loader. After reset, it holds the pipeline idle while the loader writes the program, then releases the pipeline. During run it gives the port to fetch, but still allows starvation-bounded runtime patch writes. It sits between the IF stage and the instruction memory; the memory's read path remains combinational.

## Interface
- ADDR_W, 14: byte-address width of the memory (16384 bytes).
- STARVE_MAX, 8: number of consecutive run-phase cycles a valid loader word may be refused before it is forced through.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_valid  in  1  loader word offered.
- ld_addr  in  32  byte address of the word; must be 4-aligned.
- ld_data  in  32  word; [31:24] goes to byte ld_addr.
- ld_ready  out  1  word accepted when ld_valid && ld_ready.
- ld_done  in  1  single-cycle pulse marking the end of the boot image.
- cpu_run  out  1  pipeline enable; 0 until boot completes.
- fetch_req  in  1  IF stage wants an instruction this cycle.
- fetch_pc  in  32  byte address of the instruction.
- fetch_instr  out  32  instruction, passed through from mem_rdata.
- fetch_valid  out  1  fetch_instr is valid this cycle.
- fetch_err  out  1  fetch_pc is out of range.
- mem_addr  out  32  memory address.
- mem_we  out  1  word write strobe.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  combinational read data at mem_addr.
- words_loaded  out  13  count of words written; saturates at 8191.
- err_misaligned  out  1  sticky flag: a misaligned loader word was dropped.

## Operation
- States:
  - INIT (reset state).
  - LOAD.
  - DRAIN.
  - RUN.
- State transitions:
  - INIT→LOAD unconditionally.
  - LOAD→DRAIN on ld_done.
  - DRAIN→RUN unconditionally.
  - RUN is terminal until rst.
- Write register: an accepted word is captured into wr_addr/wr_data/wr_pend. The write is issued on the next cycle: mem_we=wr_pend, mem_addr=wr_addr, mem_wdata=wr_data.
- Misaligned words (ld_addr[1:0]≠0) and out-of-range words (ld_addr > 2^ADDR_W−4):
  - The handshake still completes.
  - wr_pend stays 0 and words_loaded is unchanged.
  - err_misaligned is set on misaligned words only.
- words_loaded increments on every issued write.
- ld_ready:
  - INIT and DRAIN: 0.
  - LOAD: 1, so back-to-back accepts are allowed and writes are pipelined.
  - RUN: (!fetch_req || starve_cnt==STARVE_MAX) && !wr_pend.
- ld_done arriving in the same cycle as an accept: the word is kept. DRAIN guarantees that write issues before cpu_run rises.
- mem_addr = fetch_pc whenever wr_pend=0.
- fetch_valid = (state==RUN) && fetch_req && !wr_pend && !fetch_err.
- fetch_instr = mem_rdata whenever fetch_valid=1, else 0.
- fetch_err = fetch_req && fetch_pc > 2^ADDR_W−4 (in any state).
- starve_cnt (RUN only):
  - Increments while ld_valid && !ld_ready, saturating at STARVE_MAX.
  - Clears on accept or when ld_valid=0.
- Forced loader write in RUN (starve_cnt hit): the write cycle drops fetch_valid for exactly one cycle. The IF stage holds fetch_pc and retries.

## Timing
- Reset values:
  - state=INIT, cpu_run=0, ld_ready=0, mem_we=0.
  - wr_pend=0, words_loaded=0, err_misaligned=0, starve_cnt=0.
  - fetch_valid=0, fetch_instr=0.
- Reset takes effect immediately, including mid-load and mid-write; any pending write is discarded.
- Load latency:
  - Accept at cycle N → mem_we=1 at cycle N+1.
  - words_loaded updates at the end of N+1.
- ld_done sampled at cycle N → DRAIN at N+1 → RUN and cpu_run=1 at N+2.
- Fetch: zero-cycle combinational path, fetch_pc→mem_addr→fetch_instr, in the same cycle.
- cpu_run, state, counters and the write register are registered. ld_ready, fetch_valid, fetch_err and mem_addr are combinational.

## Test plan
- Boot and run:
  - Reset, then load 0x4808_0000 at 100 and 0x4809_0004 at 104 on consecutive cycles, then pulse ld_done.
  - mem_we is seen at 100 and 104; words_loaded=2; cpu_run=1 two cycles after ld_done.
  - Fetch of pc=104 returns 0x4809_0004 with fetch_valid=1.
- Fetch before run: fetch_req=1, pc=100 during LOAD → fetch_valid=0 throughout; mem_we is unaffected.
- Starvation:
  - In RUN, fetch_req=1 continuously and ld_valid=1 (addr 296, data 0x0C10_0008).
  - ld_ready rises after exactly 8 refused cycles; the following cycle has mem_we=1 and fetch_valid=0.
  - fetch_valid returns on the next cycle.
- Misaligned word: ld_addr=102 in LOAD → accepted, no mem_we, err_misaligned=1 (sticky), words_loaded unchanged.
- Reset mid-load:
  - rst asserted in the cycle after an accept → mem_we drops immediately.
  - After release: state INIT, words_loaded=0, cpu_run=0, ld_ready=0 for one cycle, then 1.
- Range check: fetch_pc=16381 in RUN → fetch_err=1, fetch_valid=0; fetch_pc=16380 → valid.
